// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
//
// Shares one LIFO stack between two clients. Each client raises a push or pop
// request and holds it until it sees a one-cycle ack. The arbiter grants one
// client at a time and drives single-cycle push/pop strobes to the stack.
// Pop data is returned on the winner's rdata. A push on a full stack or a pop
// on an empty stack is rejected with ack+err, and the stack is not touched.
//
// Parameters
//   DW       data width on the client side and the stack side
//   POP_LAT  edges from the stack sampling stk_pop to stk_dataout being
//            captured (>= 1)
//   FAIR     1 = round-robin between c0/c1, 0 = c0 always wins a contention
//
// Ports
//   i_clk            rising-edge clock
//   i_resetb         synchronous reset, active low
//   i_cN_req         client N request, held until o_cN_ack
//   i_cN_op          client N op: 0 = push, 1 = pop (stable while req)
//   i_cN_wdata       client N push data (stable while req)
//   o_cN_ack         client N one-cycle completion pulse
//   o_cN_err         client N op rejected (valid with ack)
//   o_cN_rdata       client N pop result, changes only on a successful pop ack
//   o_stk_push       stack push strobe
//   o_stk_pop        stack pop strobe
//   o_stk_datain     stack write data (holds its last value when idle)
//   i_stk_dataout    stack read data
//   i_stk_full       stack full flag
//   i_stk_empty      stack empty flag
// -----------------------------------------------------------------------------
module stack_arbiter #(
    parameter int unsigned DW      = 8,
    parameter int unsigned POP_LAT = 1,
    parameter int unsigned FAIR    = 1
) (
    input  logic          i_clk,
    input  logic          i_resetb,

    input  logic          i_c0_req,
    input  logic          i_c0_op,
    input  logic [DW-1:0] i_c0_wdata,
    output logic          o_c0_ack,
    output logic          o_c0_err,
    output logic [DW-1:0] o_c0_rdata,

    input  logic          i_c1_req,
    input  logic          i_c1_op,
    input  logic [DW-1:0] i_c1_wdata,
    output logic          o_c1_ack,
    output logic          o_c1_err,
    output logic [DW-1:0] o_c1_rdata,

    output logic          o_stk_push,
    output logic          o_stk_pop,
    output logic [DW-1:0] o_stk_datain,
    input  logic [DW-1:0] i_stk_dataout,
    input  logic          i_stk_full,
    input  logic          i_stk_empty
);

    // Wait counter only has to hold POP_LAT-1.
    localparam int unsigned CW = (POP_LAT > 1) ? $clog2(POP_LAT) : 1;
    localparam logic [CW-1:0] CntLoad = CW'(POP_LAT - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    // Client select encoding everywhere below: 0 = c0, 1 = c1.
    state_e        r_state;
    logic          r_last_grant;
    logic          r_win;
    logic          r_op;
    logic [CW-1:0] r_cnt;

    logic          r_c0_ack;
    logic          r_c0_err;
    logic [DW-1:0] r_c0_rdata;
    logic          r_c1_ack;
    logic          r_c1_err;
    logic [DW-1:0] r_c1_rdata;

    logic          r_stk_push;
    logic          r_stk_pop;
    logic [DW-1:0] r_stk_datain;

    logic          w_any_req;
    logic          w_win;
    logic          w_op;
    logic [DW-1:0] w_wdata;
    logic          w_illegal;

    // -------------------------------------------------------------------------
    // Arbitration and legality of the candidate transaction (used in IDLE only)
    // -------------------------------------------------------------------------
    always_comb begin
        w_any_req = i_c0_req | i_c1_req;
        if (i_c0_req && i_c1_req) begin
            // Round-robin hands the grant to whoever did not win last time.
            w_win = (FAIR != 0) ? ~r_last_grant : 1'b0;
        end else begin
            w_win = i_c1_req;
        end
        w_op      = w_win ? i_c1_op    : i_c0_op;
        w_wdata   = w_win ? i_c1_wdata : i_c0_wdata;
        w_illegal = w_op ? i_stk_empty : i_stk_full;
    end

    // -------------------------------------------------------------------------
    // Transaction FSM, all outputs registered
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_resetb) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;  // c0 wins the first contention
            r_win        <= 1'b0;
            r_op         <= 1'b0;
            r_cnt        <= '0;
            r_c0_ack     <= 1'b0;
            r_c0_err     <= 1'b0;
            r_c0_rdata   <= '0;
            r_c1_ack     <= 1'b0;
            r_c1_err     <= 1'b0;
            r_c1_rdata   <= '0;
            r_stk_push   <= 1'b0;
            r_stk_pop    <= 1'b0;
            r_stk_datain <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_win        <= w_win;
                        r_op         <= w_op;
                        r_last_grant <= w_win;
                        if (w_illegal) begin
                            // Rejected ops ack right away and never strobe the stack.
                            if (w_win) begin
                                r_c1_ack <= 1'b1;
                                r_c1_err <= 1'b1;
                            end else begin
                                r_c0_ack <= 1'b1;
                                r_c0_err <= 1'b1;
                            end
                            r_state <= StDone;
                        end else begin
                            r_stk_push   <= ~w_op;
                            r_stk_pop    <= w_op;
                            r_stk_datain <= w_wdata;
                            r_state      <= StIssue;
                        end
                    end
                end

                StIssue: begin
                    // The stack samples the strobe on this edge.
                    r_stk_push <= 1'b0;
                    r_stk_pop  <= 1'b0;
                    if (r_op) begin
                        // Pop data is valid POP_LAT edges after this one, so the
                        // capture always happens from WAIT.
                        r_cnt   <= CntLoad;
                        r_state <= StWait;
                    end else begin
                        if (r_win) begin
                            r_c1_ack <= 1'b1;
                            r_c1_err <= 1'b0;
                        end else begin
                            r_c0_ack <= 1'b1;
                            r_c0_err <= 1'b0;
                        end
                        r_state <= StDone;
                    end
                end

                StWait: begin
                    if (r_cnt == '0) begin
                        if (r_win) begin
                            r_c1_rdata <= i_stk_dataout;
                            r_c1_ack   <= 1'b1;
                            r_c1_err   <= 1'b0;
                        end else begin
                            r_c0_rdata <= i_stk_dataout;
                            r_c0_ack   <= 1'b1;
                            r_c0_err   <= 1'b0;
                        end
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end

                StDone: begin
                    // Requests seen here are ignored; the acked client drops req now.
                    r_c0_ack <= 1'b0;
                    r_c0_err <= 1'b0;
                    r_c1_ack <= 1'b0;
                    r_c1_err <= 1'b0;
                    r_state  <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_c0_ack     = r_c0_ack;
    assign o_c0_err     = r_c0_err;
    assign o_c0_rdata   = r_c0_rdata;
    assign o_c1_ack     = r_c1_ack;
    assign o_c1_err     = r_c1_err;
    assign o_c1_rdata   = r_c1_rdata;
    assign o_stk_push   = r_stk_push;
    assign o_stk_pop    = r_stk_pop;
    assign o_stk_datain = r_stk_datain;

endmodule

// File: tb/tb_stack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stack_arbiter
//
// Drives stack_arbiter (POP_LAT=3, FAIR=1) against a behavioural LIFO stack
// with a POP_LAT-deep read pipeline. Expected results come from a transaction
// level reference: a queue for the stack contents, a last-grant variable and
// the latency rules (error 1 edge, push 2 edges, pop 2+POP_LAT edges after
// req is raised; a queued loser starts one edge after the winner's ack).
// -----------------------------------------------------------------------------
module tb_stack_arbiter;

    localparam int DW      = 8;
    localparam int POP_LAT = 3;
    localparam int DEPTH   = 8;

    logic          clk = 1'b0;
    logic          resetb;
    logic          c0_req, c0_op, c0_ack, c0_err;
    logic [DW-1:0] c0_wdata, c0_rdata;
    logic          c1_req, c1_op, c1_ack, c1_err;
    logic [DW-1:0] c1_wdata, c1_rdata;
    logic          stk_push, stk_pop, stk_full, stk_empty;
    logic [DW-1:0] stk_datain, stk_dataout;
    logic [29:0]   outs;

    always #5 clk = ~clk;

    stack_arbiter #(
        .DW      (DW),
        .POP_LAT (POP_LAT),
        .FAIR    (1)
    ) u_dut (
        .i_clk         (clk),
        .i_resetb      (resetb),
        .i_c0_req      (c0_req),
        .i_c0_op       (c0_op),
        .i_c0_wdata    (c0_wdata),
        .o_c0_ack      (c0_ack),
        .o_c0_err      (c0_err),
        .o_c0_rdata    (c0_rdata),
        .i_c1_req      (c1_req),
        .i_c1_op       (c1_op),
        .i_c1_wdata    (c1_wdata),
        .o_c1_ack      (c1_ack),
        .o_c1_err      (c1_err),
        .o_c1_rdata    (c1_rdata),
        .o_stk_push    (stk_push),
        .o_stk_pop     (stk_pop),
        .o_stk_datain  (stk_datain),
        .i_stk_dataout (stk_dataout),
        .i_stk_full    (stk_full),
        .i_stk_empty   (stk_empty)
    );

    assign outs = {c0_ack, c0_err, c0_rdata, c1_ack, c1_err, c1_rdata,
                   stk_push, stk_pop, stk_datain};

    // ---------------- behavioural stack (environment) ----------------
    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] pipe [POP_LAT];
    int            sp = 0;
    bit            force_full = 1'b0;
    bit            force_empty = 1'b0;

    assign stk_full    = force_full  || (sp == DEPTH);
    assign stk_empty   = force_empty || (sp == 0);
    assign stk_dataout = pipe[POP_LAT-1];

    always @(posedge clk) begin
        pipe[0] <= 8'($urandom);  // garbage unless a pop happens
        if (stk_push === 1'b1 && sp < DEPTH) begin
            mem[sp] <= stk_datain;
            sp      <= sp + 1;
        end
        if (stk_pop === 1'b1 && sp > 0) begin
            pipe[0] <= mem[sp-1];
            sp      <= sp - 1;
        end
        for (int i = 1; i < POP_LAT; i++) pipe[i] <= pipe[i-1];
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_q [$];
    int            ref_last = 1;
    logic [DW-1:0] ref_rd [2];
    int            exp_lat [2];
    bit            exp_err [2];
    int            exp_npush, exp_npop;
    logic [DW-1:0] exp_pushed [$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int ref_pick(input bit r0, input bit r1);
        if (r0 && r1) return (ref_last == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    function automatic void ref_exec(input int c, input bit op, input logic [DW-1:0] d,
                                     output bit err, output int lat);
        ref_last = c;
        if (!op) begin
            err = force_full || (ref_q.size() >= DEPTH);
            lat = err ? 1 : 2;
            if (!err) begin
                ref_q.push_back(d);
                exp_pushed.push_back(d);
                exp_npush++;
            end
        end else begin
            err = force_empty || (ref_q.size() == 0);
            lat = err ? 1 : 2 + POP_LAT;
            if (!err) begin
                ref_rd[c] = ref_q.pop_back();
                exp_npop++;
            end
        end
    endfunction

    function automatic void ref_pair(input bit r0, input bit op0, input logic [DW-1:0] d0,
                                     input bit r1, input bit op1, input logic [DW-1:0] d1);
        bit            rq [2];
        bit            op [2];
        logic [DW-1:0] d  [2];
        int            w, lt;
        bit            e;
        rq[0] = r0; rq[1] = r1; op[0] = op0; op[1] = op1; d[0] = d0; d[1] = d1;
        exp_lat[0] = -1; exp_lat[1] = -1; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        exp_npush = 0; exp_npop = 0; exp_pushed.delete();
        w = ref_pick(r0, r1);
        ref_exec(w, op[w], d[w], e, lt);
        exp_err[w] = e; exp_lat[w] = lt;
        if (rq[0] && rq[1]) begin
            ref_exec(1 - w, op[1-w], d[1-w], e, lt);
            exp_err[1-w] = e; exp_lat[1-w] = exp_lat[w] + 1 + lt;
        end
    endfunction

    // ---------------- stimulus driver / observer ----------------
    int            obs_lat [2];
    bit            obs_err [2];
    logic [DW-1:0] obs_rd [2];
    logic [DW-1:0] obs_end_rd [2];
    int            obs_npush, obs_npop, obs_spur;
    bit            obs_tail;
    logic [DW-1:0] obs_pushed [$];

    // Called just after a falling edge; returns just after a falling edge.
    task automatic drive(input bit r0, input bit op0, input logic [DW-1:0] d0,
                         input bit r1, input bit op1, input logic [DW-1:0] d1,
                         input bit drop_early);
        bit done0, done1;
        int n;
        obs_lat[0] = -1; obs_lat[1] = -1; obs_err[0] = 1'b0; obs_err[1] = 1'b0;
        obs_rd[0] = c0_rdata; obs_rd[1] = c1_rdata;
        obs_npush = 0; obs_npop = 0; obs_spur = 0; obs_pushed.delete();
        c0_req = r0; c0_op = op0; c0_wdata = d0;
        c1_req = r1; c1_op = op1; c1_wdata = d1;
        done0 = !r0; done1 = !r1; n = 0;
        while (!(done0 && done1) && n < 40) begin
            @(negedge clk);
            n++;
            if (drop_early && n == 1) begin
                c0_req = 1'b0;
                c1_req = 1'b0;
            end
            if (stk_push) begin
                obs_npush++;
                obs_pushed.push_back(stk_datain);
            end
            if (stk_pop) obs_npop++;
            if (c0_ack) begin
                if (done0) obs_spur++;
                else begin
                    done0 = 1'b1; obs_lat[0] = n; obs_err[0] = c0_err;
                    obs_rd[0] = c0_rdata; c0_req = 1'b0;
                end
            end
            if (c1_ack) begin
                if (done1) obs_spur++;
                else begin
                    done1 = 1'b1; obs_lat[1] = n; obs_err[1] = c1_err;
                    obs_rd[1] = c1_rdata; c1_req = 1'b0;
                end
            end
        end
        c0_req = 1'b0; c1_req = 1'b0;
        @(negedge clk);
        obs_tail = c0_ack | c1_ack | stk_push | stk_pop;
        obs_end_rd[0] = c0_rdata; obs_end_rd[1] = c1_rdata;
    endtask

    task automatic apply_reset(input int cycles);
        resetb = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
        repeat (cycles) @(negedge clk);
        resetb = 1'b1;
        ref_last = 1; ref_rd[0] = '0; ref_rd[1] = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetb = 1'b0;
        c0_req = 1'b1; c0_op = 1'b0; c0_wdata = 8'hA5;
        c1_req = 1'b1; c1_op = 1'b1; c1_wdata = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== 30'd0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: got %h want 0", i, outs);
            end
        end
        c0_req = 1'b0; c1_req = 1'b0; resetb = 1'b1;
        ref_last = 1; ref_rd[0] = '0; ref_rd[1] = '0;
    endtask

    task automatic test_push_empty();
        ref_pair(1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 8'd0, 1'b0);
        n_cmp++;
        if (obs_lat[0] !== exp_lat[0]) begin
            n_bad++; $display("FAIL push_lat: got %0d want %0d", obs_lat[0], exp_lat[0]);
        end
        n_cmp++;
        if (obs_err[0] !== exp_err[0]) begin
            n_bad++; $display("FAIL push_err: got %0d want %0d", obs_err[0], exp_err[0]);
        end
        n_cmp++;
        if (obs_npush !== 1) begin
            n_bad++; $display("FAIL push_strobe_cycles: got %0d want 1", obs_npush);
        end
        n_cmp++;
        if (obs_pushed.size() != 1 || obs_pushed[0] !== 8'd10) begin
            n_bad++; $display("FAIL push_datain: got %0d items want 10", obs_pushed.size());
        end
        n_cmp++;
        if (obs_lat[1] !== -1 || obs_spur !== 0 || obs_tail !== 1'b0) begin
            n_bad++;
            $display("FAIL push_side_effects: got lat1=%0d spur=%0d tail=%0d want -1/0/0",
                     obs_lat[1], obs_spur, obs_tail);
        end
    endtask

    task automatic test_contention();
        apply_reset(2);
        ref_pair(1'b1, 1'b0, 8'd20, 1'b1, 1'b0, 8'd30);
        drive(1'b1, 1'b0, 8'd20, 1'b1, 1'b0, 8'd30, 1'b0);
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (obs_lat[c] !== exp_lat[c]) begin
                n_bad++; $display("FAIL contend1_lat_c%0d: got %0d want %0d", c, obs_lat[c], exp_lat[c]);
            end
        end
        n_cmp++;
        if (obs_pushed.size() != 2 || obs_pushed[0] !== 8'd20 || obs_pushed[1] !== 8'd30) begin
            n_bad++; $display("FAIL contend1_order: got %0d pushes want 20 then 30", obs_pushed.size());
        end
        // Second contention: c1 was served last, so c0 must win again.
        ref_pair(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'd66);
        drive(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'd66, 1'b0);
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (obs_lat[c] !== exp_lat[c]) begin
                n_bad++; $display("FAIL contend2_lat_c%0d: got %0d want %0d", c, obs_lat[c], exp_lat[c]);
            end
        end
        n_cmp++;
        if (obs_rd[0] !== ref_rd[0]) begin
            n_bad++; $display("FAIL contend2_rdata_c0: got %0d want %0d", obs_rd[0], ref_rd[0]);
        end
    endtask

    task automatic test_pop();
        ref_pair(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0);
        n_cmp++;
        if (obs_lat[1] !== exp_lat[1]) begin
            n_bad++; $display("FAIL pop_lat: got %0d want %0d", obs_lat[1], exp_lat[1]);
        end
        n_cmp++;
        if (obs_rd[1] !== ref_rd[1] || obs_err[1] !== 1'b0) begin
            n_bad++; $display("FAIL pop_rdata: got %0d err %0d want %0d err 0", obs_rd[1], obs_err[1], ref_rd[1]);
        end
        n_cmp++;
        if (obs_npop !== 1 || obs_npush !== 0) begin
            n_bad++; $display("FAIL pop_strobes: got pop=%0d push=%0d want 1/0", obs_npop, obs_npush);
        end
        n_cmp++;
        if (obs_end_rd[0] !== ref_rd[0]) begin
            n_bad++; $display("FAIL pop_other_rdata: got %0d want %0d", obs_end_rd[0], ref_rd[0]);
        end
    endtask

    task automatic test_errors();
        force_full = 1'b1;
        ref_pair(1'b1, 1'b0, 8'd99, 1'b0, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd99, 1'b0, 1'b0, 8'd0, 1'b0);
        force_full = 1'b0;
        n_cmp++;
        if (obs_lat[0] !== exp_lat[0] || obs_err[0] !== 1'b1) begin
            n_bad++; $display("FAIL full_err: got lat %0d err %0d want lat %0d err 1", obs_lat[0], obs_err[0], exp_lat[0]);
        end
        n_cmp++;
        if (obs_npush !== 0) begin
            n_bad++; $display("FAIL full_no_strobe: got %0d want 0", obs_npush);
        end
        force_empty = 1'b1;
        ref_pair(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0);
        force_empty = 1'b0;
        n_cmp++;
        if (obs_lat[1] !== exp_lat[1] || obs_err[1] !== 1'b1) begin
            n_bad++; $display("FAIL empty_err: got lat %0d err %0d want lat %0d err 1", obs_lat[1], obs_err[1], exp_lat[1]);
        end
        n_cmp++;
        if (obs_npop !== 0 || obs_end_rd[1] !== ref_rd[1]) begin
            n_bad++; $display("FAIL empty_held: got pops %0d rdata %0d want 0 / %0d", obs_npop, obs_end_rd[1], ref_rd[1]);
        end
    endtask

    task automatic test_drop_after_grant();
        ref_pair(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd55);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd55, 1'b1);
        n_cmp++;
        if (obs_lat[1] !== exp_lat[1] || obs_err[1] !== 1'b0) begin
            n_bad++; $display("FAIL drop_ack: got lat %0d err %0d want lat %0d err 0", obs_lat[1], obs_err[1], exp_lat[1]);
        end
        n_cmp++;
        if (obs_pushed.size() != 1 || obs_pushed[0] !== 8'd55) begin
            n_bad++; $display("FAIL drop_datain: got %0d pushes want one of 55", obs_pushed.size());
        end
    endtask

    task automatic test_wait_reset();
        int seen;
        c0_req = 1'b1; c0_op = 1'b1; c0_wdata = 8'd0;
        @(negedge clk);  // after E0: pop strobe up
        @(negedge clk);  // after E1: waiting for pop data
        resetb = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outs !== 30'd0) begin
            n_bad++; $display("FAIL wait_reset_outputs: got %h want 0", outs);
        end
        c0_req = 1'b0; resetb = 1'b1;
        void'(ref_q.pop_back());  // the stack did sample that pop
        ref_last = 1; ref_rd[0] = '0; ref_rd[1] = '0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (c0_ack || c1_ack || stk_push || stk_pop) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL wait_reset_no_ack: got %0d active cycles want 0", seen);
        end
        ref_pair(1'b1, 1'b0, 8'd123, 1'b0, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd123, 1'b0, 1'b0, 8'd0, 1'b0);
        n_cmp++;
        if (obs_lat[0] !== exp_lat[0] || obs_err[0] !== 1'b0 || obs_npush !== 1) begin
            n_bad++; $display("FAIL post_reset_push: got lat %0d err %0d pushes %0d want %0d/0/1",
                              obs_lat[0], obs_err[0], obs_npush, exp_lat[0]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            bit            r0, r1, op0, op1;
            logic [DW-1:0] d0, d1;
            int            sel;
            sel = $urandom_range(0, 2);
            r0  = (sel != 1);
            r1  = (sel != 0);
            op0 = ($urandom_range(0, 9) < 4);
            op1 = ($urandom_range(0, 9) < 4);
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            ref_pair(r0, op0, d0, r1, op1, d1);
            drive(r0, op0, d0, r1, op1, d1, 1'b0);
            for (int c = 0; c < 2; c++) begin
                n_cmp++;
                if (obs_lat[c] !== exp_lat[c] || obs_err[c] !== exp_err[c]) begin
                    n_bad++;
                    $display("FAIL rand%0d_c%0d_ack: got lat %0d err %0d want lat %0d err %0d",
                             it, c, obs_lat[c], obs_err[c], exp_lat[c], exp_err[c]);
                end
                n_cmp++;
                if (obs_end_rd[c] !== ref_rd[c]) begin
                    n_bad++;
                    $display("FAIL rand%0d_c%0d_rdata: got %0d want %0d", it, c, obs_end_rd[c], ref_rd[c]);
                end
            end
            n_cmp++;
            if (obs_npush !== exp_npush || obs_npop !== exp_npop || obs_spur !== 0 || obs_tail !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d_strobes: got push %0d pop %0d spur %0d tail %0d want %0d/%0d/0/0",
                         it, obs_npush, obs_npop, obs_spur, obs_tail, exp_npush, exp_npop);
            end
            for (int k = 0; k < exp_pushed.size(); k++) begin
                n_cmp++;
                if (k >= obs_pushed.size() || obs_pushed[k] !== exp_pushed[k]) begin
                    n_bad++;
                    $display("FAIL rand%0d_datain%0d: got %0d pushes want data %0d", it, k,
                             obs_pushed.size(), exp_pushed[k]);
                end
            end
        end
    endtask

    initial begin
        resetb = 1'b0;
        c0_req = 1'b0; c0_op = 1'b0; c0_wdata = '0;
        c1_req = 1'b0; c1_op = 1'b0; c1_wdata = '0;
        test_reset();
        test_push_empty();
        test_contention();
        test_pop();
        test_errors();
        test_drop_after_grant();
        test_wait_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
